// File: rtl/pipe_flow_ctrl_if.sv
// Hazard-to-pipeline control bundle: stall/mispredict requests in,
// per-stage enable/flush/redirect controls and debug counters out.
interface pipe_flow_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             stall_req;
  logic             mispredict;
  logic             pc_en;
  logic             pc_sel;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             busy;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_events;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output stall_req, mispredict,
    input  pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, exmem_flush,
    input  busy, stall_timeout, stall_events, flush_events
  );

  modport slave (
    input  stall_req, mispredict,
    output pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, exmem_flush,
    output busy, stall_timeout, stall_events, flush_events
  );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Moore sequencer turning hazard stall/mispredict requests into pipeline
// stage enables, flushes and PC redirect, with a stall watchdog and debug counters.
module pipe_flow_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 15,
  parameter int CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  pipe_flow_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LAST  = 4'(RESET_CYCLES - 1);
  localparam logic [7:0] STALL_LAST = 8'(MAX_STALL - 1);
  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic [7:0]       stall_cnt_q, stall_cnt_d;
  logic [1:0]       flush_cnt_q, flush_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_ev_q, stall_ev_d;
  logic [CNT_W-1:0] flush_ev_q, flush_ev_d;

  logic pc_en_q, pc_en_d;
  logic pc_sel_q, pc_sel_d;
  logic ifid_en_q, ifid_en_d;
  logic ifid_flush_q, ifid_flush_d;
  logic idex_flush_q, idex_flush_d;
  logic exmem_flush_q, exmem_flush_d;
  logic busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    stall_ev_d  = stall_ev_q;
    flush_ev_d  = flush_ev_q;

    case (state_q)
      HOLD: begin
        hold_cnt_d = hold_cnt_q + 4'd1;
        if (hold_cnt_q == HOLD_LAST) state_d = RUN;
      end
      RUN: begin
        if (bus.mispredict) begin
          state_d     = FLUSH;
          flush_cnt_d = 2'd0;
          if (flush_ev_q != '1) flush_ev_d = flush_ev_q + 1'b1;
        end else if (bus.stall_req) begin
          state_d     = STALL;
          stall_cnt_d = 8'd0;
          if (stall_ev_q != '1) stall_ev_d = stall_ev_q + 1'b1;
        end
      end
      STALL: begin
        stall_cnt_d = stall_cnt_q + 8'd1;
        if (bus.mispredict) begin
          state_d     = FLUSH;
          flush_cnt_d = 2'd0;
          if (flush_ev_q != '1) flush_ev_d = flush_ev_q + 1'b1;
        end else if (!bus.stall_req) begin
          state_d = RUN;
        end else if (stall_cnt_q == STALL_LAST) begin
          // Watchdog: force one RUN cycle so the pipeline cannot deadlock.
          state_d   = RUN;
          timeout_d = 1'b1;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 2'd1;
        if (flush_cnt_q == FLUSH_LAST) state_d = RUN;
      end
      default: begin
        state_d    = HOLD;
        hold_cnt_d = 4'd0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    pc_en_d       = 1'b0;
    pc_sel_d      = 1'b0;
    ifid_en_d     = 1'b0;
    ifid_flush_d  = 1'b1;
    idex_flush_d  = 1'b1;
    exmem_flush_d = 1'b1;
    busy_d        = 1'b1;
    case (state_d)
      RUN: begin
        pc_en_d       = 1'b1;
        ifid_en_d     = 1'b1;
        ifid_flush_d  = 1'b0;
        idex_flush_d  = 1'b0;
        exmem_flush_d = 1'b0;
        busy_d        = 1'b0;
      end
      STALL: begin
        ifid_flush_d  = 1'b0;
        exmem_flush_d = 1'b0;
      end
      FLUSH: begin
        pc_en_d       = 1'b1;
        ifid_en_d     = 1'b1;
        exmem_flush_d = 1'b0;
        pc_sel_d      = (flush_cnt_d == 2'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= HOLD;
      hold_cnt_q    <= 4'd0;
      stall_cnt_q   <= 8'd0;
      flush_cnt_q   <= 2'd0;
      timeout_q     <= 1'b0;
      stall_ev_q    <= '0;
      flush_ev_q    <= '0;
      pc_en_q       <= 1'b0;
      pc_sel_q      <= 1'b0;
      ifid_en_q     <= 1'b0;
      ifid_flush_q  <= 1'b1;
      idex_flush_q  <= 1'b1;
      exmem_flush_q <= 1'b1;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      timeout_q     <= timeout_d;
      stall_ev_q    <= stall_ev_d;
      flush_ev_q    <= flush_ev_d;
      pc_en_q       <= pc_en_d;
      pc_sel_q      <= pc_sel_d;
      ifid_en_q     <= ifid_en_d;
      ifid_flush_q  <= ifid_flush_d;
      idex_flush_q  <= idex_flush_d;
      exmem_flush_q <= exmem_flush_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.pc_en         = pc_en_q;
  assign bus.pc_sel        = pc_sel_q;
  assign bus.ifid_en       = ifid_en_q;
  assign bus.ifid_flush    = ifid_flush_q;
  assign bus.idex_flush    = idex_flush_q;
  assign bus.exmem_flush   = exmem_flush_q;
  assign bus.busy          = busy_q;
  assign bus.stall_timeout = timeout_q;
  assign bus.stall_events  = stall_ev_q;
  assign bus.flush_events  = flush_ev_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl: expected control vectors are queued as
// each step is driven and popped after the following clock edge.
module tb_pipe_flow_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipe_flow_ctrl_if #(.CNT_W(16)) bus ();
  pipe_flow_ctrl_if #(.CNT_W(2))  bus_s ();

  pipe_flow_ctrl #(.RESET_CYCLES(2), .FLUSH_CYCLES(2), .MAX_STALL(15), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Narrow-counter copy fed the same stimulus, used to reach saturation quickly.
  pipe_flow_ctrl #(.RESET_CYCLES(2), .FLUSH_CYCLES(2), .MAX_STALL(15), .CNT_W(2)) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (bus_s)
  );

  assign bus_s.stall_req  = bus.stall_req;
  assign bus_s.mispredict = bus.mispredict;

  // {pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, exmem_flush, busy}
  localparam logic [6:0] V_HOLD  = 7'b0_0_0_1_1_1_1;
  localparam logic [6:0] V_RUN   = 7'b1_0_1_0_0_0_0;
  localparam logic [6:0] V_STALL = 7'b0_0_0_0_1_0_1;
  localparam logic [6:0] V_FL1   = 7'b1_1_1_1_1_0_1;
  localparam logic [6:0] V_FL2   = 7'b1_0_1_1_1_0_1;

  int tests  = 0;
  int failed = 0;
  logic [6:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic m, input logic [6:0] e, input string tag);
    logic [6:0] obs;
    logic [6:0] exp;
    bus.stall_req  = s;
    bus.mispredict = m;
    sb.push_back(e);
    @(posedge clock);
    #1;
    obs = {bus.pc_en, bus.pc_sel, bus.ifid_en, bus.ifid_flush,
           bus.idex_flush, bus.exmem_flush, bus.busy};
    exp = sb.pop_front();
    $display("[TB] %-12s stall=%0b mp=%0b ctrl=%b exp=%b", tag, s, m, obs, exp);
    chk(tag, {25'd0, obs}, {25'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input int st, input int fl, input logic to);
    chk({tag, "_stall_ev"}, {16'd0, bus.stall_events}, st);
    chk({tag, "_flush_ev"}, {16'd0, bus.flush_events}, fl);
    chk({tag, "_timeout"}, {31'd0, bus.stall_timeout}, {31'd0, to});
    chk({tag, "_sat_stall"}, {30'd0, bus_s.stall_events}, (st > 3) ? 3 : st);
    chk({tag, "_sat_flush"}, {30'd0, bus_s.flush_events}, (fl > 3) ? 3 : fl);
  endtask

  initial begin
    // Reset for one cycle; inputs during HOLD are ignored.
    reset = 1'b1;
    step(1'b0, 1'b0, V_HOLD, "reset");
    chk_cnt("after_reset", 0, 0, 1'b0);
    reset = 1'b0;
    step(1'b1, 1'b1, V_HOLD, "hold_ign");
    step(1'b0, 1'b0, V_RUN,  "hold_done");
    chk_cnt("run0", 0, 0, 1'b0);

    // Three-cycle stall.
    step(1'b1, 1'b0, V_STALL, "stall1");
    step(1'b1, 1'b0, V_STALL, "stall2");
    step(1'b1, 1'b0, V_STALL, "stall3");
    step(1'b0, 1'b0, V_RUN,   "stall_exit");
    chk_cnt("stall3", 1, 0, 1'b0);

    // Single mispredict pulse.
    step(1'b0, 1'b1, V_FL1, "mp_flush1");
    step(1'b0, 1'b0, V_FL2, "mp_flush2");
    step(1'b0, 1'b0, V_RUN, "mp_exit");
    chk_cnt("mp", 1, 1, 1'b0);

    // Mispredict beats stall in RUN; stall ignored inside FLUSH.
    step(1'b1, 1'b1, V_FL1, "both_fl1");
    chk_cnt("both", 1, 2, 1'b0);
    step(1'b1, 1'b0, V_FL2,   "both_fl2");
    step(1'b1, 1'b0, V_RUN,   "both_exit");
    step(1'b1, 1'b0, V_STALL, "restall");
    step(1'b1, 1'b1, V_FL1,   "stall_mp1");
    step(1'b1, 1'b0, V_FL2,   "stall_mp2");
    step(1'b1, 1'b0, V_RUN,   "stall_mp_ex");
    step(1'b0, 1'b0, V_RUN,   "idle");
    chk_cnt("stall_mp", 2, 3, 1'b0);

    // Watchdog: 15 STALL cycles, forced RUN, then re-stall.
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, V_STALL, "wd_stall");
    chk({"wd_pre", "_timeout"}, {31'd0, bus.stall_timeout}, 32'd0);
    step(1'b1, 1'b0, V_RUN,   "wd_release");
    chk_cnt("wd_rel", 3, 3, 1'b1);
    step(1'b1, 1'b0, V_STALL, "wd_restall");
    chk_cnt("wd_re", 4, 3, 1'b1);

    // Reset during STALL wins over both requests.
    reset = 1'b1;
    step(1'b1, 1'b1, V_HOLD, "rst_stall");
    chk_cnt("rst_stall", 0, 0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0, V_HOLD, "rel_hold");
    step(1'b0, 1'b0, V_RUN,  "rel_run");

    // Reset during FLUSH.
    step(1'b0, 1'b1, V_FL1, "pre_rst_fl");
    chk_cnt("pre_rst_fl", 0, 1, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0, V_HOLD, "rst_flush");
    chk_cnt("rst_flush", 0, 0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0, V_HOLD, "rel_hold2");
    step(1'b0, 1'b0, V_RUN,  "rel_run2");

    // Drive the narrow counters past all-ones; they must hold.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, V_STALL, "sat_stall");
      step(1'b0, 1'b0, V_RUN,   "sat_run");
    end
    chk_cnt("sat", 5, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
